me_mv_decode: RTL

Sequential decoder at the output end of the motion-estimation minimum tree. It accepts the packed winner index and minimum SAD produced by the comparator tree and recovers the candidate number. It converts that number into a signed motion vector (dx, dy) by iterative row/column division. The result is presented on a valid/ready output toward the mode-decision stage.

---
 rtl/me_pkg.sv | 23 ++
 rtl/me_mv_decode.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/me_pkg.sv
// me_pkg -- definitions shared by the motion-vector decode slice.
//   ME_BIT_WIDTH    : default SAD width, equal to the comparator-tree element width
//   me_state_e      : decoder FSM states (IDLE / DECODE / OUT)
//   cand_from_index : turns a packed tree index into a candidate number
package me_pkg;

    localparam int ME_BIT_WIDTH = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUT    = 2'd2
    } me_state_e;

    // A tree bit of 1 means the lower-numbered half won at that level.
    // Inverting every bit therefore yields the candidate number directly.
    // The argument is 32 bits wide so that any index width can use it; the
    // caller keeps only its own low bits of the result.
    function automatic logic [31:0] cand_from_index(input logic [31:0] index);
        return ~index;
    endfunction

endpackage

// File: rtl/me_mv_decode.sv
// me_mv_decode -- converts the winner of the motion-estimation minimum tree
// into a signed motion vector. It divides the candidate number by the window
// width using repeated subtraction, one step per cycle.
//
// Ports
//   clk, rst   : clock; asynchronous active-high reset
//   in_valid   : index/SAD pair present
//   in_ready   : block can accept a pair (high only in IDLE)
//   in_index   : packed tree index, MSB = root decision
//   in_sad     : minimum SAD from the tree
//   out_valid  : result present (held until out_ready)
//   out_ready  : downstream accepts the result
//   mv_x, mv_y : signed dx = column - RANGE, dy = row - RANGE
//   out_sad    : in_sad from the accepted pair, unchanged
//   out_err    : candidate number lies outside the search window
module me_mv_decode
    import me_pkg::*;
#(
    parameter int BIT_WIDTH   = ME_BIT_WIDTH,
    parameter int INDEX_WIDTH = 6,
    parameter int SEARCH_W    = 8,
    parameter int SEARCH_H    = 8,
    parameter int RANGE       = 4,
    parameter int MV_WIDTH    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INDEX_WIDTH-1:0]     in_index,
    input  logic [BIT_WIDTH-1:0]       in_sad,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [MV_WIDTH-1:0] mv_x,
    output logic signed [MV_WIDTH-1:0] mv_y,
    output logic [BIT_WIDTH-1:0]       out_sad,
    output logic                       out_err
);

    // All arithmetic uses one spare bit so that a borrow shows up as the MSB.
    localparam int XW = INDEX_WIDTH + 1;
    localparam logic [XW-1:0] NUM_CAND  = XW'(SEARCH_W * SEARCH_H);
    localparam logic [XW-1:0] WIDTH_EXT = XW'(SEARCH_W);
    localparam logic [XW-1:0] RANGE_EXT = XW'(RANGE);

    me_state_e                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]      rem_q, rem_d;
    logic [INDEX_WIDTH-1:0]      row_q, row_d;
    logic [BIT_WIDTH-1:0]        sad_q, sad_d;
    logic                        err_q, err_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [MV_WIDTH-1:0]  mv_x_q, mv_x_d;
    logic signed [MV_WIDTH-1:0]  mv_y_q, mv_y_d;

    logic [INDEX_WIDTH-1:0]      cand;
    logic [XW-1:0]               rem_sub;
    logic                        rem_ge_w;
    logic [XW-1:0]               dx_full;
    logic [XW-1:0]               dy_full;

    assign cand     = INDEX_WIDTH'(cand_from_index(32'(in_index)));
    assign rem_sub  = {1'b0, rem_q} - WIDTH_EXT;
    // No borrow out of the extended subtraction means rem >= SEARCH_W.
    assign rem_ge_w = ~rem_sub[XW-1];
    // Two's-complement difference; the signed cast below sign-extends or
    // truncates it to the vector width.
    assign dx_full  = {1'b0, rem_q} - RANGE_EXT;
    assign dy_full  = {1'b0, row_q} - RANGE_EXT;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        row_d       = row_q;
        sad_d       = sad_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        mv_x_d      = mv_x_q;
        mv_y_d      = mv_y_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = cand;
                    row_d   = '0;
                    sad_d   = in_sad;
                    err_d   = ({1'b0, cand} >= NUM_CAND);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (err_q) begin
                    mv_x_d      = '0;
                    mv_y_d      = '0;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else if (rem_ge_w) begin
                    rem_d = rem_sub[INDEX_WIDTH-1:0];
                    row_d = row_q + 1'b1;
                end else begin
                    mv_x_d      = MV_WIDTH'($signed(dx_full));
                    mv_y_d      = MV_WIDTH'($signed(dy_full));
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                // No bypass: a new pair is accepted only after a full IDLE cycle.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples its next-state value from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            row_q       <= '0;
            sad_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            row_q       <= row_d;
            sad_q       <= sad_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            mv_x_q      <= mv_x_d;
            mv_y_q      <= mv_y_d;
        end
    end

    // in_ready is decoded from registered state only, so it has no
    // combinational path from out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign mv_x      = mv_x_q;
    assign mv_y      = mv_y_q;
    assign out_sad   = sad_q;
    assign out_err   = err_q;

endmodule
